sc_colision_nv: RTL and testbench
=================================

Name: sc_colision_nv

Overview:
- Lane reader and collision monitor; sits at the consumer end of the vehicle-lane shift-register bus.
- Samples one lane's 8-bit parallel vehicle pattern together with the frog's one-hot column mask for that lane.
- On overlap, raises a collision pulse, decrements lives, and holds a request until the game top acknowledges the respawn.
- Applies an invulnerability hold-off after each acknowledged hit and flags game-over when lives reach zero.

Parameters:
- DATAWIDTH_BUS, 8, width of the lane pattern and frog mask buses.
- DATAWIDTH_LIVES, 2, width of the lives counter.
- LIVES_INIT, 3, lives loaded at reset; range 1..2^DATAWIDTH_LIVES-1.
- DATAWIDTH_HOLDOFF, 5, width of the hold-off counter.
- HOLDOFF_CYCLES, 16, number of invulnerable cycles after ACK; range 1..2^DATAWIDTH_HOLDOFF.

Ports:
- SC_COLISION_CLOCK_50  in  1  system clock.
- SC_COLISION_RESET  in  1  reset, synchronous, active-high.
- SC_COLISION_LANE_IN  in  DATAWIDTH_BUS  vehicle pattern of one lane; 1 = vehicle present in that cell.
- SC_COLISION_FROG_IN  in  DATAWIDTH_BUS  frog mask for this lane; one-hot, or all zero when the frog is not in this lane.
- SC_COLISION_ENABLE_IN  in  1  game running.
- SC_COLISION_ACK_IN  in  1  top-level acknowledge of the hit/respawn.
- SC_COLISION_HIT_OUT  out  1  one-cycle collision pulse.
- SC_COLISION_PENDING_OUT  out  1  hit awaiting ACK.
- SC_COLISION_LIVES_OUT  out  DATAWIDTH_LIVES  remaining lives.
- SC_COLISION_GAMEOVER_OUT  out  1  lives exhausted.
- SC_COLISION_STATE_OUT  out  3  state encoding, for debug.

Behaviour:
- Single clock. Reset is synchronous and active-high; all state changes on the rising edge of SC_COLISION_CLOCK_50.
- Reset values:
  - state = IDLE
  - HIT_OUT = 0, PENDING_OUT = 0, GAMEOVER_OUT = 0
  - LIVES_OUT = LIVES_INIT
  - hold-off counter = 0
  - sample registers = 0
- Reset wins over every other input in the same cycle, including mid-HIT and mid-HOLDOFF.
- Sample stage: overlap_q <= |(LANE_IN & FROG_IN), registered every cycle. Inputs present before edge n give overlap_q valid after edge n.
- State encoding (STATE_OUT): IDLE=0, MONITOR=1, HIT=2, HOLDOFF=3, GAMEOVER=4.
- IDLE:
  - ENABLE_IN=1 -> MONITOR.
  - Overlaps are ignored.
- MONITOR:
  - ENABLE_IN=0 -> IDLE; lives are retained.
  - Otherwise, hit condition true -> HIT_OUT=1 for exactly one cycle and lives <= lives-1.
    - If the new lives value is 0 -> GAMEOVER.
    - Else -> HIT, with PENDING_OUT=1.
  - Latency: overlap present at the inputs before edge n gives HIT_OUT high in the cycle after edge n+1 (2 clocks).
- HIT:
  - PENDING_OUT=1.
  - ENABLE_IN is ignored; the hit must be acknowledged.
  - ACK_IN=1 -> PENDING_OUT=0, counter <= HOLDOFF_CYCLES-1, go to HOLDOFF.
  - ACK_IN held high for several cycles counts once.
  - ACK_IN outside HIT is ignored.
- HOLDOFF:
  - Overlaps are ignored.
  - Counter decrements each cycle; at counter=0 -> MONITOR. HOLDOFF lasts exactly HOLDOFF_CYCLES cycles.
  - ENABLE_IN=0 -> IDLE and counter cleared.
- GAMEOVER:
  - GAMEOVER_OUT=1, LIVES_OUT=0.
  - Absorbing state; only reset exits.
- Lives never wrap: the decrement is guarded so it never goes below 0.
- Simultaneous events:
  - Overlap and ENABLE_IN falling in MONITOR: disable wins, no hit.
  - Overlap on the same cycle as the HOLDOFF->MONITOR transition: not counted; evaluated from the next cycle.
- Multi-cell overlap, e.g. FROG_IN & LANE_IN with several bits set, is a single hit.

Optional Feature:
- Macro: SC_COLISION_EDGE_DETECT_EN.
- Defined: the hit condition is a rising edge of overlap (overlap_q=1 and overlap_prev=0).
  - overlap_prev is a register updated every cycle and reset to 0.
  - An overlap already in progress when entering MONITOR, e.g. a frog still under a car after hold-off, does not hit until it clears and re-occurs.
- Undefined: the hit condition is overlap_q=1 (level) in MONITOR. No overlap_prev register is built.

Test Plan:
- Reset, ENABLE=1, LANE=8'b0000_1111, FROG=8'b0001_0000 for 20 cycles -> state=MONITOR, HIT_OUT never 1, LIVES_OUT=3.
- In MONITOR, set FROG=8'b0000_0100 with LANE=8'b0000_1111 before edge n -> HIT_OUT=1 only in the cycle after edge n+1, LIVES_OUT=2, PENDING_OUT=1, state=HIT.
- In HIT, pulse ACK_IN 1 cycle with overlap held -> PENDING_OUT=0, state=HOLDOFF for exactly 16 cycles, no HIT_OUT. Then MONITOR: without the macro, HIT_OUT fires 2 cycles later and LIVES_OUT=1; with SC_COLISION_EDGE_DETECT_EN, no hit until FROG is cleared to 0 for one cycle and re-set.
- Three hit/ACK sequences from reset -> LIVES_OUT 3->2->1->0. Third hit: HIT_OUT=1, GAMEOVER_OUT=1, PENDING_OUT=0. Further overlap or ACK causes no change; reset restores LIVES_OUT=3, state=IDLE.
- In MONITOR, drop ENABLE_IN on the same cycle the overlap appears -> state=IDLE, no HIT_OUT, LIVES_OUT unchanged. In HIT, drop ENABLE_IN -> state stays HIT until ACK.
- Assert RESET synchronously mid-HOLDOFF with counter=7 -> next cycle state=IDLE, counter=0, LIVES_OUT=3, all flags 0.

Source files
------------

// File: rtl/sc_colision_nv.sv
// sc_colision_nv: lane reader and frog collision monitor.
// Registers the overlap of one lane's vehicle pattern with the frog mask.
// On a hit it pulses HIT_OUT, takes a life and holds a respawn request until
// ACK_IN. After that it ignores overlaps for a fixed hold-off window, and it
// latches game-over once the lives run out.
// Optional build macro: SC_COLISION_EDGE_DETECT_EN. When it is defined, only a
// rising edge of the registered overlap counts as a hit. When it is undefined,
// the level of the overlap counts.
module sc_colision_nv #(
  parameter int unsigned DATAWIDTH_BUS     = 8,
  parameter int unsigned DATAWIDTH_LIVES   = 2,
  parameter int unsigned LIVES_INIT        = 3,
  parameter int unsigned DATAWIDTH_HOLDOFF = 5,
  parameter int unsigned HOLDOFF_CYCLES    = 16
) (
  input  logic                       SC_COLISION_CLOCK_50,
  input  logic                       SC_COLISION_RESET,
  input  logic [DATAWIDTH_BUS-1:0]   SC_COLISION_LANE_IN,
  input  logic [DATAWIDTH_BUS-1:0]   SC_COLISION_FROG_IN,
  input  logic                       SC_COLISION_ENABLE_IN,
  input  logic                       SC_COLISION_ACK_IN,
  output logic                       SC_COLISION_HIT_OUT,
  output logic                       SC_COLISION_PENDING_OUT,
  output logic [DATAWIDTH_LIVES-1:0] SC_COLISION_LIVES_OUT,
  output logic                       SC_COLISION_GAMEOVER_OUT,
  output logic [2:0]                 SC_COLISION_STATE_OUT
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MONITOR  = 3'd1,
    ST_HIT      = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam logic [DATAWIDTH_LIVES-1:0]   LIVES_RST    = DATAWIDTH_LIVES'(LIVES_INIT);
  localparam logic [DATAWIDTH_LIVES-1:0]   LIVES_ONE    = DATAWIDTH_LIVES'(1);
  localparam logic [DATAWIDTH_HOLDOFF-1:0] HOLDOFF_LOAD = DATAWIDTH_HOLDOFF'(HOLDOFF_CYCLES - 1);
  localparam logic [DATAWIDTH_HOLDOFF-1:0] HOLDOFF_ONE  = DATAWIDTH_HOLDOFF'(1);

  state_t                       state_q, state_d;
  logic [DATAWIDTH_LIVES-1:0]   lives_q, lives_d;
  logic [DATAWIDTH_HOLDOFF-1:0] cnt_q, cnt_d;
  logic                         hit_q, hit_d;
  logic                         pending_q, pending_d;
  logic                         gameover_q, gameover_d;
  logic                         overlap_q, overlap_d;
  logic                         hit_cond_c;

  assign overlap_d = |(SC_COLISION_LANE_IN & SC_COLISION_FROG_IN);

`ifdef SC_COLISION_EDGE_DETECT_EN
  logic overlap_prev_q;

  // Delayed overlap so that only a fresh overlap counts as a hit
  always_ff @(posedge SC_COLISION_CLOCK_50) begin
    if (SC_COLISION_RESET) overlap_prev_q <= 1'b0;
    else                   overlap_prev_q <= overlap_q;
  end

  assign hit_cond_c = overlap_q & ~overlap_prev_q;
`else
  assign hit_cond_c = overlap_q;
`endif

  // Sample stage and FSM/output registers
  always_ff @(posedge SC_COLISION_CLOCK_50) begin
    if (SC_COLISION_RESET) begin
      state_q    <= ST_IDLE;
      lives_q    <= LIVES_RST;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      pending_q  <= 1'b0;
      gameover_q <= 1'b0;
      overlap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      pending_q  <= pending_d;
      gameover_q <= gameover_d;
      overlap_q  <= overlap_d;
    end
  end

  // Next-state, lives, hold-off counter and flag logic
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    hit_d      = 1'b0;
    pending_d  = pending_q;
    gameover_d = gameover_q;
    unique case (state_q)
      ST_IDLE: begin
        if (SC_COLISION_ENABLE_IN) state_d = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (!SC_COLISION_ENABLE_IN) begin
          state_d = ST_IDLE;
        end else if (hit_cond_c) begin
          hit_d = 1'b1;
          if (lives_q != '0) lives_d = lives_q - LIVES_ONE;
          if (lives_q <= LIVES_ONE) begin
            state_d    = ST_GAMEOVER;
            gameover_d = 1'b1;
            pending_d  = 1'b0;
          end else begin
            state_d   = ST_HIT;
            pending_d = 1'b1;
          end
        end
      end
      ST_HIT: begin
        // Only the first acknowledged cycle matters, because the state moves on
        if (SC_COLISION_ACK_IN) begin
          pending_d = 1'b0;
          cnt_d     = HOLDOFF_LOAD;
          state_d   = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (!SC_COLISION_ENABLE_IN) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_MONITOR;
        end else begin
          cnt_d = cnt_q - HOLDOFF_ONE;
        end
      end
      ST_GAMEOVER: begin
        gameover_d = 1'b1;
        pending_d  = 1'b0;
        lives_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign SC_COLISION_HIT_OUT      = hit_q;
  assign SC_COLISION_PENDING_OUT  = pending_q;
  assign SC_COLISION_LIVES_OUT    = lives_q;
  assign SC_COLISION_GAMEOVER_OUT = gameover_q;
  assign SC_COLISION_STATE_OUT    = state_q;

endmodule

// File: tb/tb_sc_colision_nv.sv
// Testbench for sc_colision_nv.
// A driver applies directed and random stimulus and steps a behavioural game
// model, then queues the outputs it expects after each clock edge. A separate
// monitor pops those expectations just after each rising edge and compares
// them against the DUT outputs.
module tb_sc_colision_nv;

  localparam int HOLDOFF = 16;
  localparam int LIVES0  = 3;

  localparam int S_IDLE = 0, S_MON = 1, S_HIT = 2, S_HOLD = 3, S_GO = 4;

  typedef struct packed {
    logic       hit;
    logic       pending;
    logic [1:0] lives;
    logic       go;
    logic [2:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [7:0] lane, frog;
  logic       hit_o, pend_o, go_o;
  logic [1:0] lives_o;
  logic [2:0] st_o;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Game model state
  int m_mode  = S_IDLE;
  int m_lives = LIVES0;
  int m_hold  = 0;  // cycles of hold-off still to spend, including the current one
  bit m_ov    = 0;
  bit m_prev  = 0;
  bit m_hit   = 0;

  sc_colision_nv dut (
    .SC_COLISION_CLOCK_50    (clk),
    .SC_COLISION_RESET       (rst),
    .SC_COLISION_LANE_IN     (lane),
    .SC_COLISION_FROG_IN     (frog),
    .SC_COLISION_ENABLE_IN   (en),
    .SC_COLISION_ACK_IN      (ack),
    .SC_COLISION_HIT_OUT     (hit_o),
    .SC_COLISION_PENDING_OUT (pend_o),
    .SC_COLISION_LIVES_OUT   (lives_o),
    .SC_COLISION_GAMEOVER_OUT(go_o),
    .SC_COLISION_STATE_OUT   (st_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Advance the model by one rising edge, given the inputs seen at that edge
  task automatic model_step();
    bit cond;
`ifdef SC_COLISION_EDGE_DETECT_EN
    cond = m_ov && !m_prev;
`else
    cond = m_ov;
`endif
    m_hit = 0;
    if (rst) begin
      m_mode = S_IDLE; m_lives = LIVES0; m_hold = 0; m_ov = 0; m_prev = 0;
    end else begin
      case (m_mode)
        S_IDLE: if (en) m_mode = S_MON;
        S_MON: begin
          if (!en) m_mode = S_IDLE;
          else if (cond) begin
            m_hit = 1;
            if (m_lives > 0) m_lives = m_lives - 1;
            m_mode = (m_lives == 0) ? S_GO : S_HIT;
          end
        end
        S_HIT: if (ack) begin m_mode = S_HOLD; m_hold = HOLDOFF; end
        S_HOLD: begin
          if (!en) begin m_mode = S_IDLE; m_hold = 0; end
          else begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_mode = S_MON;
          end
        end
        default: ;
      endcase
      m_prev = m_ov;
      m_ov   = (lane & frog) != 8'h00;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic a,
                       input logic [7:0] l, input logic [7:0] f);
    exp_t x;
    rst = r; en = e; ack = a; lane = l; frog = f;
    model_step();
    x.hit     = m_hit;
    x.pending = (m_mode == S_HIT);
    x.lives   = 2'(m_lives);
    x.go      = (m_mode == S_GO);
    x.st      = 3'(m_mode);
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic r, input logic e, input logic a,
                     input logic [7:0] l, input logic [7:0] f);
    for (int i = 0; i < n; i++) drive(r, e, a, l, f);
  endtask

  // Monitor: compare the outputs after each edge with the oldest expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("hit",      int'(hit_o),   int'(x.hit));
        chk("pending",  int'(pend_o),  int'(x.pending));
        chk("lives",    int'(lives_o), int'(x.lives));
        chk("gameover", int'(go_o),    int'(x.go));
        chk("state",    int'(st_o),    int'(x.st));
      end
    end
  end

  initial begin
    logic [7:0] f;
    rst = 1'b1; en = 1'b0; ack = 1'b0; lane = 8'h00; frog = 8'h00;

    // Reset, then a frog next to the cars without touching them
    run(2, 1, 0, 0, 8'h00, 8'h00);
    run(20, 0, 1, 0, 8'h0F, 8'h10);
    // Overlap appears; the hit follows, then HIT ignores a dropped enable
    run(5, 0, 1, 0, 8'h0F, 8'h04);
    run(3, 0, 0, 0, 8'h0F, 8'h04);
    // ACK held for three cycles, overlap kept through hold-off and beyond
    run(3, 0, 1, 1, 8'h0F, 8'h04);
    run(25, 0, 1, 0, 8'h0F, 8'h04);
    // Clear and re-set the frog so that an edge-sensitive build also hits
    run(2, 0, 1, 0, 8'h0F, 8'h00);
    run(5, 0, 1, 0, 8'h0F, 8'h04);
    // Keep hitting until game over, using a multi-cell overlap
    for (int k = 0; k < 3; k++) begin
      run(1, 0, 1, 1, 8'h0F, 8'h00);
      run(20, 0, 1, 0, 8'h0F, 8'h00);
      run(4, 0, 1, 0, 8'hFF, 8'h0C);
    end
    // Game over is absorbing; only reset leaves it
    run(5, 0, 1, 1, 8'h0F, 8'h04);
    run(3, 0, 0, 0, 8'h0F, 8'h04);
    run(2, 1, 1, 1, 8'h0F, 8'h04);
    // Enable drops while the registered overlap is present: no hit
    run(1, 0, 0, 0, 8'h00, 8'h00);
    run(3, 0, 1, 0, 8'h0F, 8'h00);
    run(1, 0, 1, 0, 8'h0F, 8'h04);
    run(3, 0, 0, 0, 8'h0F, 8'h04);
    // Enable drops in the same cycle the overlap appears at the inputs
    run(3, 0, 1, 0, 8'h0F, 8'h00);
    run(3, 0, 0, 0, 8'h0F, 8'h04);
    // Reset in the middle of hold-off
    run(3, 0, 1, 0, 8'h0F, 8'h04);
    run(1, 0, 1, 1, 8'h0F, 8'h00);
    run(8, 0, 1, 0, 8'h0F, 8'h00);
    run(1, 1, 1, 0, 8'h0F, 8'h04);
    run(3, 0, 0, 0, 8'h00, 8'h00);
    // Hold-off interrupted by a disable
    run(4, 0, 1, 0, 8'h0F, 8'h04);
    run(1, 0, 1, 1, 8'h0F, 8'h00);
    run(5, 0, 1, 0, 8'h0F, 8'h00);
    run(3, 0, 0, 0, 8'h0F, 8'h00);
    // Random play
    for (int i = 0; i < 3000; i++) begin
      f = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      drive(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 15) != 0),
            logic'($urandom_range(0, 3) == 0),
            8'($urandom), f);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
